game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 The parameters SHALL be: BIRD_X, 100, fixed bird column in pixels; PIPE_W, 40, pipe width in pixels; GAP_H, 120, pipe gap height in pixels; FLOOR_Y, 10, bird_y at or below which the bird hits the ground; CEIL_Y, 470, bird_y at or above which the bird hits the ceiling; DEAD_FRAMES, 60, frames spent in DEAD.
REQ-002 The clock and reset SHALL be: clk, in, 1, system clock; rst_n, in, 1, asynchronous active-low reset.
REQ-003 The data inputs SHALL be: btn, in, 1, raw player button, active-high, asynchronous to clk; frame_tick, in, 1, one-cycle pulse per video frame; bird_y, in, 10, bird height, larger means higher; pipe_x, in, 10, left edge of current pipe; gap_y, in, 10, bottom edge of current pipe gap.
REQ-004 The outputs SHALL be: freeze, out, 1, halts bird and pipe motion; flap, out, 1, one-cycle flap command to the bird; restart, out, 1, one-cycle pulse to reload bird and pipe positions; state, out, 2, current FSM state; score, out, 8, current score; hi_score, out, 8, best score since reset.

Function
REQ-005 btn SHALL pass through a 2-FF synchronizer, and a rising edge of the synchronized signal SHALL produce an internal one-cycle btn_rise, 3 cycles after btn changes.
REQ-006 The FSM SHALL have four states: IDLE=0, PLAY=1, DEAD=2, OVER=3. state SHALL equal the FSM register directly.
REQ-007 IDLE transition: on btn_rise, go to PLAY. In the same cycle, restart=1 for one cycle and score clears to 0.
REQ-008 PLAY transition: on a frame_tick cycle with collision true, go to DEAD and clear the frame counter to 0.
REQ-009 DEAD transition: the frame counter increments on each frame_tick; when the frame_tick that brings it to DEAD_FRAMES arrives, go to OVER.
REQ-010 OVER transition: on btn_rise, go to IDLE.
REQ-011 Any btn_rise in DEAD SHALL be ignored.
REQ-012 freeze SHALL be registered and equal 0 only while state==PLAY. It deasserts the cycle after the IDLE→PLAY edge and reasserts the cycle after the PLAY→DEAD edge.
REQ-013 Collision SHALL be true when any of these holds: bird_y <= FLOOR_Y; bird_y >= CEIL_Y; or pipe_x <= BIRD_X, pipe_x + PIPE_W > BIRD_X, and (bird_y < gap_y or bird_y >= gap_y + GAP_H).
REQ-014 Collision sums SHALL be computed at 11 bits so they cannot wrap.
REQ-015 Flap pending flag: btn_rise in PLAY SHALL set it.
REQ-016 Flap pulse: on a frame_tick in PLAY with the pending flag set, flap SHALL be 1 for exactly the next cycle and the pending flag SHALL clear. Multiple btn_rise events between ticks SHALL yield only one flap.
REQ-017 flap SHALL never assert outside PLAY. The pending flag SHALL clear on any exit from PLAY.
REQ-018 Scoring: a per-pipe cleared flag SHALL be set, and score incremented by 1, on the first frame_tick in PLAY where pipe_x + PIPE_W <= BIRD_X. The flag SHALL clear when pipe_x + PIPE_W > BIRD_X, so each pipe scores once.
REQ-019 score SHALL saturate at 255.
REQ-020 When collision and a pass occur on the same frame_tick, collision SHALL win: go to DEAD with no increment.
REQ-021 When btn_rise coincides with a collision tick, the FSM SHALL go to DEAD and no flap SHALL be issued.
REQ-022 On the DEAD→OVER edge, hi_score SHALL load score if score > hi_score.
REQ-023 score SHALL hold its value through DEAD, OVER and IDLE until the next IDLE→PLAY edge.
REQ-024 Inputs SHALL be ignored on cycles without frame_tick, except btn.

Reset
REQ-025 rst_n low SHALL asynchronously force: state=IDLE, freeze=1, flap=0, restart=0, score=0, hi_score=0, frame counter=0, pending and cleared flags=0, synchronizer flops=0.
REQ-026 Reset mid-game SHALL abandon the game with no hi_score update.
REQ-027 After rst_n rises, a btn already held high SHALL NOT generate btn_rise until it is released and pressed again.

Verification
REQ-028 Start: reset, hold bird_y=200 and pipe_x=600, pulse btn -> restart=1 for exactly one cycle, state=1 and freeze=0 the cycle after, score=0.
REQ-029 Flap merge: in PLAY, press btn 3 times between two frame_ticks -> exactly one flap pulse, on the cycle after the next frame_tick; no flap on the following tick.
REQ-030 Score: in PLAY with gap_y=150 and bird_y=200, sweep pipe_x from 120 down to 50 in steps of 10 per tick -> score goes 0→1 at pipe_x=60, with no collision.
REQ-031 Pipe hit: in PLAY with gap_y=250, bird_y=200, apply a tick with pipe_x=90 -> state=2 and freeze=1 the cycle after; after 60 more ticks state=3 and hi_score=score.
REQ-032 Ground and tie: in PLAY with bird_y=10, apply a tick coinciding with btn_rise -> state=2, flap stays 0, score unchanged.
REQ-033 Reset mid-game: in PLAY with score=5 and hi_score=3, assert rst_n=0 asynchronously -> all outputs at reset values immediately, hi_score=0.

Source files
------------

// File: rtl/game_ctrl.sv
// Game controller for a flappy-bird style game: button synchronizer, game FSM,
// collision detection, flap scheduling, scoring and best-score tracking.
module game_ctrl #(
   parameter int unsigned BIRD_X      = 100,
   parameter int unsigned PIPE_W      = 40,
   parameter int unsigned GAP_H       = 120,
   parameter int unsigned FLOOR_Y     = 10,
   parameter int unsigned CEIL_Y      = 470,
   parameter int unsigned DEAD_FRAMES = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   input  logic       frame_tick,
   input  logic [9:0] bird_y,
   input  logic [9:0] pipe_x,
   input  logic [9:0] gap_y,
   output logic       freeze,
   output logic       flap,
   output logic       restart,
   output logic [1:0] state,
   output logic [7:0] score,
   output logic [7:0] hi_score
);

   localparam int unsigned CNT_W = $clog2(DEAD_FRAMES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_DEAD = 2'd2,
      S_OVER = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             btn_s1_q, btn_s2_q, btn_s3_q;
   logic [1:0]       fill_q, fill_d;
   logic             armed_q, armed_d;
   logic             freeze_q, freeze_d;
   logic             flap_q, flap_d;
   logic             restart_q, restart_d;
   logic [7:0]       score_q, score_d;
   logic [7:0]       hi_score_q, hi_score_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             pending_q, pending_d;
   logic             cleared_q, cleared_d;

   logic             btn_rise;
   logic             collision;
   logic             pipe_passed;
   logic [10:0]      by_w, px_w, gy_w;

   // A button held across reset must be seen released before any edge counts;
   // fill_q waits until the synchronizer holds real samples.
   always_comb begin
      fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
      armed_d = armed_q | ((fill_q == 2'd2) & ~btn_s2_q);
   end

   assign btn_rise = armed_q & btn_s2_q & ~btn_s3_q;

   // All comparisons at 11 bits so the pipe and gap sums never wrap.
   always_comb begin
      by_w = {1'b0, bird_y};
      px_w = {1'b0, pipe_x};
      gy_w = {1'b0, gap_y};
      collision = (by_w <= 11'(FLOOR_Y)) ||
                  (by_w >= 11'(CEIL_Y)) ||
                  ((px_w <= 11'(BIRD_X)) &&
                   ((px_w + 11'(PIPE_W)) > 11'(BIRD_X)) &&
                   ((by_w < gy_w) || (by_w >= (gy_w + 11'(GAP_H)))));
      pipe_passed = (px_w + 11'(PIPE_W)) <= 11'(BIRD_X);
   end

   always_comb begin
      state_d     = state_q;
      flap_d      = 1'b0;
      restart_d   = 1'b0;
      score_d     = score_q;
      hi_score_d  = hi_score_q;
      frame_cnt_d = frame_cnt_q;
      pending_d   = pending_q;
      cleared_d   = cleared_q;

      case (state_q)
         S_IDLE: begin
            if (btn_rise) begin
               state_d   = S_PLAY;
               restart_d = 1'b1;
               score_d   = 8'd0;
               pending_d = 1'b0;
               cleared_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PLAY: begin
            if (frame_tick && collision) begin
               state_d     = S_DEAD;
               frame_cnt_d = '0;
               pending_d   = 1'b0;
            end else if (frame_tick) begin
               if (pending_q) begin
                  flap_d    = 1'b1;
                  pending_d = 1'b0;
               end else begin
                  flap_d = 1'b0;
               end
               if (pipe_passed && !cleared_q) begin
                  cleared_d = 1'b1;
                  score_d   = (score_q == 8'd255) ? score_q : score_q + 8'd1;
               end else if (!pipe_passed) begin
                  cleared_d = 1'b0;
               end else begin
                  cleared_d = cleared_q;
               end
            end else begin
               state_d = S_PLAY;
            end
            // A press on the collision tick is dropped along with the game.
            if (btn_rise && (state_d == S_PLAY)) begin
               pending_d = 1'b1;
            end else begin
               pending_d = pending_d;
            end
         end
         S_DEAD: begin
            if (frame_tick) begin
               frame_cnt_d = frame_cnt_q + CNT_W'(1);
               if (frame_cnt_q == CNT_W'(DEAD_FRAMES - 1)) begin
                  state_d = S_OVER;
                  if (score_q > hi_score_q) begin
                     hi_score_d = score_q;
                  end else begin
                     hi_score_d = hi_score_q;
                  end
               end else begin
                  state_d = S_DEAD;
               end
            end else begin
               state_d = S_DEAD;
            end
         end
         S_OVER: begin
            if (btn_rise) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_OVER;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      freeze_d = (state_d != S_PLAY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_s1_q    <= 1'b0;
         btn_s2_q    <= 1'b0;
         btn_s3_q    <= 1'b0;
         fill_q      <= 2'd0;
         armed_q     <= 1'b0;
         state_q     <= S_IDLE;
         freeze_q    <= 1'b1;
         flap_q      <= 1'b0;
         restart_q   <= 1'b0;
         score_q     <= 8'd0;
         hi_score_q  <= 8'd0;
         frame_cnt_q <= '0;
         pending_q   <= 1'b0;
         cleared_q   <= 1'b0;
      end else begin
         btn_s1_q    <= btn;
         btn_s2_q    <= btn_s1_q;
         btn_s3_q    <= btn_s2_q;
         fill_q      <= fill_d;
         armed_q     <= armed_d;
         state_q     <= state_d;
         freeze_q    <= freeze_d;
         flap_q      <= flap_d;
         restart_q   <= restart_d;
         score_q     <= score_d;
         hi_score_q  <= hi_score_d;
         frame_cnt_q <= frame_cnt_d;
         pending_q   <= pending_d;
         cleared_q   <= cleared_d;
      end
   end

   assign state    = state_q;
   assign freeze   = freeze_q;
   assign flap     = flap_q;
   assign restart  = restart_q;
   assign score    = score_q;
   assign hi_score = hi_score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl.
module tb_game_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn;
   logic       frame_tick;
   logic [9:0] bird_y, pipe_x, gap_y;
   logic       freeze, flap, restart;
   logic [1:0] state;
   logic [7:0] score, hi_score;

   int errors = 0;
   int checks = 0;

   game_ctrl dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .frame_tick(frame_tick),
      .bird_y(bird_y), .pipe_x(pipe_x), .gap_y(gap_y),
      .freeze(freeze), .flap(flap), .restart(restart),
      .state(state), .score(score), .hi_score(hi_score)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; the tick is sampled by the following rising edge.
   task automatic tick(input logic [9:0] px, input logic [9:0] gy, input logic [9:0] by);
      pipe_x     = px;
      gap_y      = gy;
      bird_y     = by;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic press();
      btn = 1'b1;
      repeat (3) @(negedge clk);
      btn = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic pass_pipe();
      tick(10'd120, 10'd150, 10'd200);
      tick(10'd50, 10'd150, 10'd200);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_freeze"}, 32'(freeze), 32'd1);
      check({tag, "_flap"}, 32'(flap), 32'd0);
      check({tag, "_restart"}, 32'(restart), 32'd0);
      check({tag, "_score"}, 32'(score), 32'd0);
      check({tag, "_hi"}, 32'(hi_score), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; btn = 1'b1; frame_tick = 1'b0;
      bird_y = 10'd200; pipe_x = 10'd600; gap_y = 10'd150;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");

      // Button held through reset release must not start a game.
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("held_btn_state", 32'(state), 32'd0);
      check("held_btn_restart", 32'(restart), 32'd0);
      btn = 1'b0;
      repeat (4) @(negedge clk);

      // Start: rise lands on the third edge after btn goes high.
      btn = 1'b1;
      repeat (2) @(negedge clk);
      check("start_pre_state", 32'(state), 32'd0);
      @(negedge clk);
      check("start_state", 32'(state), 32'd1);
      check("start_restart", 32'(restart), 32'd1);
      check("start_freeze", 32'(freeze), 32'd0);
      check("start_score", 32'(score), 32'd0);
      btn = 1'b0;
      @(negedge clk);
      check("start_restart_once", 32'(restart), 32'd0);
      check("start_state_hold", 32'(state), 32'd1);
      repeat (2) @(negedge clk);

      // Flap merge: three presses between ticks -> one flap.
      press(); press(); press();
      check("merge_no_early_flap", 32'(flap), 32'd0);
      tick(10'd600, 10'd150, 10'd200);
      check("merge_flap", 32'(flap), 32'd1);
      @(negedge clk);
      check("merge_flap_once", 32'(flap), 32'd0);
      tick(10'd600, 10'd150, 10'd200);
      check("merge_no_second_flap", 32'(flap), 32'd0);

      // Score sweep: pass registers at pipe_x=60.
      for (int px = 120; px >= 50; px -= 10) begin
         tick(10'(px), 10'd150, 10'd200);
         check($sformatf("sweep_score_px%0d", px), 32'(score), (px <= 60) ? 32'd1 : 32'd0);
         check($sformatf("sweep_state_px%0d", px), 32'(state), 32'd1);
      end

      // Pipe hit, then DEAD ignores presses and lasts 60 ticks.
      tick(10'd90, 10'd250, 10'd200);
      check("hit_state", 32'(state), 32'd2);
      check("hit_freeze", 32'(freeze), 32'd1);
      check("hit_score", 32'(score), 32'd1);
      press();
      check("dead_ignores_btn", 32'(state), 32'd2);
      repeat (59) tick(10'd90, 10'd250, 10'd200);
      check("dead_59_state", 32'(state), 32'd2);
      tick(10'd90, 10'd250, 10'd200);
      check("over_state", 32'(state), 32'd3);
      check("over_hi", 32'(hi_score), 32'd1);

      press();
      check("idle_state", 32'(state), 32'd0);
      check("idle_score_hold", 32'(score), 32'd1);
      check("idle_freeze", 32'(freeze), 32'd1);
      press();
      check("game2_state", 32'(state), 32'd1);
      check("game2_score", 32'(score), 32'd0);

      // Three passes, then ground collision with btn_rise and a pass on the same tick.
      repeat (3) pass_pipe();
      check("game2_score3", 32'(score), 32'd3);
      tick(10'd120, 10'd150, 10'd200);
      btn = 1'b1;
      repeat (2) @(negedge clk);
      tick(10'd50, 10'd150, 10'd10);
      check("tie_state", 32'(state), 32'd2);
      check("tie_flap", 32'(flap), 32'd0);
      check("tie_score", 32'(score), 32'd3);
      @(negedge clk);
      check("tie_flap_after", 32'(flap), 32'd0);
      btn = 1'b0;
      repeat (3) @(negedge clk);
      repeat (60) tick(10'd600, 10'd150, 10'd200);
      check("game2_over", 32'(state), 32'd3);
      check("game2_hi", 32'(hi_score), 32'd3);

      // Game 3 to score 5, then asynchronous reset mid-cycle.
      press(); press();
      check("game3_state", 32'(state), 32'd1);
      repeat (5) pass_pipe();
      check("game3_score", 32'(score), 32'd5);
      check("game3_hi", 32'(hi_score), 32'd3);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midgame_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Saturation and ceiling boundary.
      press();
      check("sat_state", 32'(state), 32'd1);
      repeat (256) pass_pipe();
      check("sat_score", 32'(score), 32'd255);
      tick(10'd600, 10'd150, 10'd469);
      check("ceil_469_state", 32'(state), 32'd1);
      tick(10'd600, 10'd150, 10'd11);
      check("floor_11_state", 32'(state), 32'd1);
      tick(10'd600, 10'd150, 10'd470);
      check("ceil_470_state", 32'(state), 32'd2);
      check("ceil_470_score", 32'(score), 32'd255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
